// File: rtl/audio_pkg.sv
// Shared audio definitions for the clip playback sequencer and the I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_BITS_DFLT = 16;
  localparam int CLIP_LEN_DFLT    = 64;

  typedef logic signed [SAMPLE_BITS_DFLT-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } play_state_t;

endpackage

// File: rtl/clip_playback_ctrl.sv
// Clip playback sequencer: walks a single-clip sample memory, holds each
// sample for a programmable number of I2S frames and hands it to the
// serializer on frame_req. Handles start/stop/pause/loop control.
module clip_playback_ctrl
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DFLT,
  parameter int CLIP_LEN    = CLIP_LEN_DFLT,
  parameter int ADDR_W      = $clog2(CLIP_LEN),
  parameter int DIV_W       = 8
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   cmd_start,
  input  logic                   cmd_stop,
  input  logic                   cmd_pause,
  input  logic                   loop_en,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic                   frame_req,
  output logic [ADDR_W-1:0]      clip_rd_addr,
  input  logic [SAMPLE_BITS-1:0] clip_rd_data,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_LEN - 1);
  localparam logic [DIV_W-1:0]  ONE_DIV   = DIV_W'(1);

  play_state_t                   state_q, state_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic                          issue_q, issue_d;   // address on clip_rd_addr is a fresh request
  logic                          land_q, land_d;     // clip_rd_data carries that request's sample
  logic signed [SAMPLE_BITS-1:0] pf_q, pf_d;
  logic                          pf_vld_q, pf_vld_d;
  logic [DIV_W-1:0]              rep_cnt_q, rep_cnt_d;
  logic [DIV_W-1:0]              div_q, div_d;       // repeat count latched when the sample is loaded
  logic                          end_q, end_d;       // last sample of a non-looping clip is playing
  logic signed [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic                          sample_valid_q, sample_valid_d;
  logic                          done_q, done_d;
  logic                          underrun_q, underrun_d;
  logic [DIV_W-1:0]              div_cur, div_eff;

  // Next-state logic: prefetch capture, command handling, then frame service.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    issue_d        = 1'b0;
    land_d         = issue_q;
    pf_d           = pf_q;
    pf_vld_d       = pf_vld_q;
    rep_cnt_d      = rep_cnt_q;
    div_d          = div_q;
    end_d          = end_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    div_cur        = (rate_div == '0) ? ONE_DIV : rate_div;
    div_eff        = (rep_cnt_q == '0) ? div_cur : div_q;

    if (land_q) begin
      pf_d     = clip_rd_data;
      pf_vld_d = 1'b1;
    end

    if (cmd_stop) begin
      // A stop in IDLE still masks a coincident start.
      if (state_q != IDLE) begin
        state_d   = IDLE;
        addr_d    = '0;
        land_d    = 1'b0;
        pf_vld_d  = 1'b0;
        rep_cnt_d = '0;
        end_d     = 1'b0;
        sample_d  = '0;
      end
    end else if (cmd_start) begin
      state_d   = PLAY;
      addr_d    = '0;
      issue_d   = 1'b1;
      land_d    = 1'b0;
      pf_vld_d  = 1'b0;
      rep_cnt_d = '0;
      end_d     = 1'b0;
    end else if (cmd_pause && (state_q == PLAY)) begin
      state_d = PAUSE;
    end else if (cmd_pause && (state_q == PAUSE)) begin
      state_d = PLAY;
    end else if (frame_req && (state_q == PLAY)) begin
      if (end_q) begin
        // The final sample has had all its frames: fall silent.
        state_d   = IDLE;
        addr_d    = '0;
        pf_vld_d  = 1'b0;
        rep_cnt_d = '0;
        end_d     = 1'b0;
        sample_d  = '0;
        done_d    = 1'b1;
      end else if (!pf_vld_q) begin
        underrun_d = 1'b1;
      end else begin
        if (rep_cnt_q == '0) begin
          sample_d       = pf_q;
          sample_valid_d = 1'b1;
          div_d          = div_cur;
        end
        if (rep_cnt_q == (div_eff - ONE_DIV)) begin
          rep_cnt_d = '0;
          if ((addr_q == LAST_ADDR) && !loop_en) begin
            end_d = 1'b1;
          end else begin
            addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            issue_d  = 1'b1;
            land_d   = 1'b0;
            pf_vld_d = 1'b0;
          end
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      issue_q        <= 1'b0;
      land_q         <= 1'b0;
      pf_vld_q       <= 1'b0;
      rep_cnt_q      <= '0;
      end_q          <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      issue_q        <= issue_d;
      land_q         <= land_d;
      pf_vld_q       <= pf_vld_d;
      rep_cnt_q      <= rep_cnt_d;
      end_q          <= end_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      underrun_q     <= underrun_d;
    end
  end

  // Prefetch data and latched repeat count; qualified by their control flags.
  always_ff @(posedge mclk) begin
    pf_q  <= pf_d;
    div_q <= div_d;
  end

  assign clip_rd_addr = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_clip_playback_ctrl.sv
// Bench for clip_playback_ctrl: directed scenarios with literal expectations
// plus randomized control traffic, all checked against a frame-level model.
module tb_clip_playback_ctrl;

  localparam int SB = 16;
  localparam int CL = 4;
  localparam int AW = 2;
  localparam int DW = 8;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0, cmd_stop = 1'b0, cmd_pause = 1'b0;
  logic          loop_en = 1'b1;
  logic [DW-1:0] rate_div = 8'd1;
  logic          frame_req = 1'b0;
  logic [AW-1:0] clip_rd_addr;
  logic [SB-1:0] clip_rd_data = '0;
  logic [SB-1:0] sample_out;
  logic          sample_valid, busy, done, underrun;

  logic signed [SB-1:0] rom [0:CL-1];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  clip_playback_ctrl #(.SAMPLE_BITS(SB), .CLIP_LEN(CL), .ADDR_W(AW), .DIV_W(DW)) dut (
    .mclk(mclk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_pause(cmd_pause), .loop_en(loop_en), .rate_div(rate_div),
    .frame_req(frame_req), .clip_rd_addr(clip_rd_addr), .clip_rd_data(clip_rd_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 mclk = ~mclk;

  // Clip memory: synchronous read, one cycle of latency.
  always @(posedge mclk) clip_rd_data <= rom[clip_rd_addr];

  // ---------------- frame-level reference model ----------------
  // st: 0 idle, 1 playing, 2 paused. idx: clip position of the next/current
  // sample; held: frames left for the sample on the output; ready: first
  // cycle on which a frame may consume the fetched sample.
  int cyc = 0;
  int st = 0, idx = 0, held = 0, ready = 0;
  bit ending = 0;
  int e_sample = 0;
  bit e_valid = 0, e_done = 0, e_under = 0;

  always @(posedge mclk) begin
    cyc++;
    e_valid = 0; e_done = 0; e_under = 0;
    if (rst) begin
      st = 0; idx = 0; held = 0; ending = 0; e_sample = 0;
    end else if (cmd_stop) begin
      if (st != 0) begin
        st = 0; idx = 0; held = 0; ending = 0; e_sample = 0;
      end
    end else if (cmd_start) begin
      st = 1; idx = 0; held = 0; ending = 0; ready = cyc + 3;
    end else if (cmd_pause && st != 0) begin
      st = (st == 1) ? 2 : 1;
    end else if (frame_req && st == 1) begin
      if (ending) begin
        st = 0; idx = 0; held = 0; ending = 0; e_sample = 0; e_done = 1;
      end else if (cyc < ready) begin
        e_under = 1;
      end else begin
        if (held == 0) begin
          e_sample = int'(rom[idx]);
          e_valid  = 1;
          held     = (rate_div == 0) ? 1 : int'(rate_div);
        end
        held--;
        if (held == 0) begin
          if (idx == CL - 1 && !loop_en) ending = 1;
          else begin
            idx   = (idx + 1) % CL;
            ready = cyc + 3;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge mclk) begin
    if (chk_en) begin
      chk("sample_out",   int'($signed(sample_out)), e_sample);
      chk("sample_valid", int'(sample_valid), int'(e_valid));
      chk("busy",         int'(busy), (st != 0) ? 1 : 0);
      chk("done",         int'(done), int'(e_done));
      chk("underrun",     int'(underrun), int'(e_under));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge mclk);
  endtask

  task automatic frame();
    frame_req = 1'b1; step(); frame_req = 1'b0;
  endtask

  task automatic start();
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
  endtask

  task automatic stop();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
  endtask

  task automatic pause();
    cmd_pause = 1'b1; step(); cmd_pause = 1'b0;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    chk(name, act, exp);
  endtask

  initial begin
    int seq [8];
    seq = '{100, 200, 300, 400, 100, 200, 300, 400};
    rom[0] = 16'sd100; rom[1] = 16'sd200; rom[2] = 16'sd300; rom[3] = 16'sd400;

    // Reset state
    step(); chk_en = 1'b1;
    repeat (2) step();
    lit("rst_sample", int'($signed(sample_out)), 0);
    lit("rst_busy", int'(busy), 0);
    lit("rst_addr", int'(clip_rd_addr), 0);
    rst = 1'b0;
    step();

    // Looping playback at rate 1, one frame every 64 cycles
    rate_div = 8'd1; loop_en = 1'b1;
    start();
    repeat (63) step();
    for (int k = 0; k < 8; k++) begin
      frame();
      lit("loop_val", int'($signed(sample_out)), seq[k]);
      lit("loop_vld", int'(sample_valid), 1);
      repeat (63) step();
    end
    stop();

    // Rate 3, no loop: each value for 3 frames, then done and silence
    rate_div = 8'd3; loop_en = 1'b0;
    start();
    repeat (5) step();
    for (int k = 0; k < 12; k++) begin
      frame();
      lit("rate3_val", int'($signed(sample_out)), 100 * (k / 3 + 1));
      lit("rate3_vld", int'(sample_valid), (k % 3 == 0) ? 1 : 0);
      lit("rate3_done", int'(done), 0);
      repeat (9) step();
    end
    frame();
    lit("end_done", int'(done), 1);
    lit("end_busy", int'(busy), 0);
    lit("end_sample", int'($signed(sample_out)), 0);
    repeat (20) step();

    // Pause holds 200, resume continues at 300
    rate_div = 8'd1; loop_en = 1'b1;
    start();
    repeat (5) step();
    frame(); repeat (9) step();
    frame(); repeat (9) step();
    lit("pre_pause", int'($signed(sample_out)), 200);
    pause();
    for (int k = 0; k < 5; k++) begin
      repeat (5) step();
      frame();
      lit("pause_hold", int'($signed(sample_out)), 200);
      lit("pause_vld", int'(sample_valid), 0);
    end
    pause();
    repeat (5) step();
    frame();
    lit("resume", int'($signed(sample_out)), 300);

    // frame_req one cycle after start underruns
    stop();
    start();
    frame();
    lit("under_pulse", int'(underrun), 1);
    lit("under_sample", int'($signed(sample_out)), 0);
    step();
    frame();
    lit("after_under", int'($signed(sample_out)), 100);
    repeat (9) step();

    // Stop coincident with frame_req while playing 300
    frame(); repeat (9) step();
    frame(); repeat (9) step();
    lit("before_stop", int'($signed(sample_out)), 300);
    cmd_stop = 1'b1; frame_req = 1'b1; step(); cmd_stop = 1'b0; frame_req = 1'b0;
    lit("stop_busy", int'(busy), 0);
    lit("stop_sample", int'($signed(sample_out)), 0);
    start();
    repeat (5) step();
    frame();
    lit("restart", int'($signed(sample_out)), 100);
    repeat (9) step();

    // Reset mid-clip with rate 0, then rate 0 behaves as rate 1
    rate_div = 8'd0;
    frame(); repeat (9) step();
    rst = 1'b1; step(); rst = 1'b0;
    lit("mrst_busy", int'(busy), 0);
    lit("mrst_sample", int'($signed(sample_out)), 0);
    lit("mrst_addr", int'(clip_rd_addr), 0);
    lit("mrst_vld", int'(sample_valid), 0);
    start();
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      frame();
      lit("rate0_val", int'($signed(sample_out)), seq[k]);
      repeat (9) step();
    end
    stop();
    repeat (4) step();

    // Randomized control traffic with a random clip
    for (int i = 0; i < CL; i++) rom[i] = 16'($urandom());
    for (int c = 0; c < 6000; c++) begin
      rst       = ($urandom_range(0, 599) == 0);
      cmd_start = ($urandom_range(0, 59) == 0);
      cmd_stop  = ($urandom_range(0, 149) == 0);
      cmd_pause = ($urandom_range(0, 49) == 0);
      frame_req = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 199) == 0) rate_div = 8'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_pause = 1'b0; frame_req = 1'b0;
    repeat (4) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
